command_parse_and_encapsulate_mux: RTL and testbench

Parameterised successor to the fixed three-channel command parse/encapsulate stage in the TSMP agent's local access control path.
- Parse path: dispatches 66-bit NMAC command words to the HCP or to one of P_EXT_NUM TSSTSE channels by destination ID.
- Encapsulate path: buffers 64-bit commands from one interior and P_EXT_NUM external sources in per-source FIFOs, then merges them round-robin onto one 66-bit output with valid/ready back-pressure.
- Adds source tagging and saturating drop counters.

---
 rtl/command_parse_and_encapsulate_mux.sv | 213 +++++++++++++++++++++
 tb/tb_command_parse_and_encapsulate_mux.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_parse_and_encapsulate_mux.sv
// NMAC command parser (HCP / TSSTSE dispatch) and round-robin encapsulation
// merge of interior and external command sources with drop accounting.
module command_parse_and_encapsulate_mux #(
    parameter int P_EXT_NUM    = 3,
    parameter int P_FIFO_DEPTH = 8,
    parameter int P_TAG_SRC    = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [65:0]               iv_command,
    input  logic                      i_command_wr,
    output logic [63:0]               ov_hcp_command,
    output logic                      o_hcp_command_wr,
    output logic [64*P_EXT_NUM-1:0]   ov_tsstse_command,
    output logic [P_EXT_NUM-1:0]      o_tsstse_command_wr,
    input  logic [63:0]               iv_command_from_interior,
    input  logic                      i_command_wr_from_interior,
    input  logic [64*P_EXT_NUM-1:0]   iv_command_from_external,
    input  logic [P_EXT_NUM-1:0]      i_command_wr_from_external,
    output logic [65:0]               ov_command,
    output logic                      o_command_wr,
    input  logic                      i_command_rdy,
    output logic [15:0]               ov_parse_drop_cnt,
    output logic [15:0]               ov_fifo_drop_cnt
);

    localparam int NS = P_EXT_NUM + 1;
    localparam int AW = $clog2(P_FIFO_DEPTH);
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    // ---------------- parse path ----------------
    logic [1:0]               cmd_type;
    logic [7:0]               cmd_dest;
    logic                     parse_ok;
    logic [63:0]              hcp_cmd_q, hcp_cmd_d;
    logic                     hcp_wr_q, hcp_wr_d;
    logic [64*P_EXT_NUM-1:0]  ts_cmd_q, ts_cmd_d;
    logic [P_EXT_NUM-1:0]     ts_wr_q, ts_wr_d;
    logic [15:0]              parse_drop_q, parse_drop_d;

    assign cmd_type = iv_command[65:64];
    assign cmd_dest = iv_command[63:56];
    assign parse_ok = i_command_wr && (cmd_type == 2'b01)
                      && (cmd_dest <= 8'(P_EXT_NUM));

    always_comb begin
        hcp_cmd_d    = hcp_cmd_q;
        hcp_wr_d     = 1'b0;
        ts_cmd_d     = ts_cmd_q;
        ts_wr_d      = '0;
        parse_drop_d = parse_drop_q;
        if (parse_ok) begin
            if (cmd_dest == 8'd0) begin
                hcp_cmd_d = iv_command[63:0];
                hcp_wr_d  = 1'b1;
            end
            for (int k = 0; k < P_EXT_NUM; k++) begin
                if (cmd_dest == 8'(k + 1)) begin
                    ts_cmd_d[64*k +: 64] = iv_command[63:0];
                    ts_wr_d[k]           = 1'b1;
                end
            end
        end else if (i_command_wr && (parse_drop_q != 16'hFFFF)) begin
            parse_drop_d = parse_drop_q + 16'd1;
        end
    end

    // ---------------- source FIFOs ----------------
    logic [63:0]   mem_q [NS][P_FIFO_DEPTH];
    logic [AW:0]   wptr_q [NS];
    logic [AW:0]   wptr_d [NS];
    logic [AW:0]   rptr_q [NS];
    logic [AW:0]   rptr_d [NS];
    logic [63:0]   src_word [NS];
    logic [NS-1:0] src_wr;
    logic [NS-1:0] empty;
    logic [NS-1:0] full;
    logic [NS-1:0] push;
    logic [NS-1:0] pop;
    logic [NS-1:0] drop;
    logic [16:0]   fifo_sum;
    logic [15:0]   fifo_drop_q, fifo_drop_d;

    assign src_wr = {i_command_wr_from_external, i_command_wr_from_interior};

    always_comb begin
        src_word[0] = iv_command_from_interior;
        for (int k = 0; k < P_EXT_NUM; k++) begin
            src_word[k+1] = iv_command_from_external[64*k +: 64];
        end
    end

    always_comb begin
        for (int s = 0; s < NS; s++) begin
            empty[s] = (wptr_q[s] == rptr_q[s]);
            full[s]  = (wptr_q[s][AW] != rptr_q[s][AW])
                       && (wptr_q[s][AW-1:0] == rptr_q[s][AW-1:0]);
        end
    end

    // ---------------- arbiter ----------------
    logic          slot_free;
    logic          grant_vld;
    logic [IW-1:0] grant_idx;
    logic [IW:0]   cand;
    logic [IW-1:0] rr_q, rr_d;

    assign slot_free = !o_command_wr || i_command_rdy;

    // Search starts at the index after the last grant (rr_q).
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NS; i++) begin
            cand = {1'b0, rr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NS)) begin
                cand = cand - (IW+1)'(NS);
            end
            if (slot_free && !grant_vld && !empty[cand[IW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        fifo_sum    = {1'b0, fifo_drop_q};
        fifo_drop_d = fifo_drop_q;
        for (int s = 0; s < NS; s++) begin
            pop[s]    = grant_vld && (grant_idx == IW'(s));
            push[s]   = src_wr[s] && (!full[s] || pop[s]);
            drop[s]   = src_wr[s] && full[s] && !pop[s];
            wptr_d[s] = wptr_q[s] + (AW+1)'(push[s]);
            rptr_d[s] = rptr_q[s] + (AW+1)'(pop[s]);
            fifo_sum  = fifo_sum + 17'(drop[s]);
        end
        fifo_drop_d = fifo_sum[16] ? 16'hFFFF : fifo_sum[15:0];
    end

    // ---------------- output register ----------------
    logic [65:0]   cmd_q, cmd_d;
    logic          cmd_wr_q, cmd_wr_d;
    logic [63:0]   head;

    always_comb begin
        cmd_d    = cmd_q;
        cmd_wr_d = cmd_wr_q;
        rr_d     = rr_q;
        head     = mem_q[grant_idx][rptr_q[grant_idx][AW-1:0]];
        if (slot_free) begin
            cmd_wr_d = grant_vld;
        end
        if (grant_vld) begin
            cmd_d[65:64] = (grant_idx == '0) ? 2'b01 : 2'b10;
            cmd_d[63:0]  = head;
            if (P_TAG_SRC != 0) begin
                cmd_d[63:56] = 8'(grant_idx);
            end
            rr_d = (grant_idx == IW'(NS - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hcp_cmd_q    <= '0;
            hcp_wr_q     <= 1'b0;
            ts_cmd_q     <= '0;
            ts_wr_q      <= '0;
            parse_drop_q <= '0;
            fifo_drop_q  <= '0;
            cmd_q        <= '0;
            cmd_wr_q     <= 1'b0;
            rr_q         <= '0;
            for (int s = 0; s < NS; s++) begin
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
            end
        end else begin
            hcp_cmd_q    <= hcp_cmd_d;
            hcp_wr_q     <= hcp_wr_d;
            ts_cmd_q     <= ts_cmd_d;
            ts_wr_q      <= ts_wr_d;
            parse_drop_q <= parse_drop_d;
            fifo_drop_q  <= fifo_drop_d;
            cmd_q        <= cmd_d;
            cmd_wr_q     <= cmd_wr_d;
            rr_q         <= rr_d;
            for (int s = 0; s < NS; s++) begin
                wptr_q[s] <= wptr_d[s];
                rptr_q[s] <= rptr_d[s];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int s = 0; s < NS; s++) begin
            if (push[s]) begin
                mem_q[s][wptr_q[s][AW-1:0]] <= src_word[s];
            end
        end
    end

    assign ov_hcp_command      = hcp_cmd_q;
    assign o_hcp_command_wr    = hcp_wr_q;
    assign ov_tsstse_command   = ts_cmd_q;
    assign o_tsstse_command_wr = ts_wr_q;
    assign ov_command          = cmd_q;
    assign o_command_wr        = cmd_wr_q;
    assign ov_parse_drop_cnt   = parse_drop_q;
    assign ov_fifo_drop_cnt    = fifo_drop_q;

endmodule

// File: tb/tb_command_parse_and_encapsulate_mux.sv
// Bench for command_parse_and_encapsulate_mux: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_command_parse_and_encapsulate_mux;

    localparam int N  = 3;
    localparam int D  = 8;
    localparam int NS = N + 1;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [65:0]       iv_command;
    logic              i_command_wr;
    logic [63:0]       ov_hcp_command;
    logic              o_hcp_command_wr;
    logic [64*N-1:0]   ov_tsstse_command;
    logic [N-1:0]      o_tsstse_command_wr;
    logic [63:0]       iv_command_from_interior;
    logic              i_command_wr_from_interior;
    logic [64*N-1:0]   iv_command_from_external;
    logic [N-1:0]      i_command_wr_from_external;
    logic [65:0]       ov_command;
    logic              o_command_wr;
    logic              i_command_rdy;
    logic [15:0]       ov_parse_drop_cnt;
    logic [15:0]       ov_fifo_drop_cnt;

    always #5 i_clk = ~i_clk;

    command_parse_and_encapsulate_mux #(
        .P_EXT_NUM(N), .P_FIFO_DEPTH(D), .P_TAG_SRC(1)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .iv_command(iv_command),
        .i_command_wr(i_command_wr),
        .ov_hcp_command(ov_hcp_command),
        .o_hcp_command_wr(o_hcp_command_wr),
        .ov_tsstse_command(ov_tsstse_command),
        .o_tsstse_command_wr(o_tsstse_command_wr),
        .iv_command_from_interior(iv_command_from_interior),
        .i_command_wr_from_interior(i_command_wr_from_interior),
        .iv_command_from_external(iv_command_from_external),
        .i_command_wr_from_external(i_command_wr_from_external),
        .ov_command(ov_command),
        .o_command_wr(o_command_wr),
        .i_command_rdy(i_command_rdy),
        .ov_parse_drop_cnt(ov_parse_drop_cnt),
        .ov_fifo_drop_cnt(ov_fifo_drop_cnt)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [63:0]     mq [NS][$];
    bit              m_ov;
    logic [65:0]     m_oc;
    int              m_next;
    int              m_pd;
    int              m_fd;
    logic [63:0]     m_hcp;
    bit              m_hwr;
    logic [64*N-1:0] m_ts;
    logic [N-1:0]    m_twr;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int g;
        int dest;
        int drops;
        logic [63:0] w;
        m_hwr = 1'b0;
        m_twr = '0;
        if (i_rst) begin
            for (int s = 0; s < NS; s++) mq[s].delete();
            m_ov = 0; m_oc = '0; m_next = 0; m_pd = 0; m_fd = 0;
            m_hcp = '0; m_ts = '0;
            return;
        end
        if (i_command_wr) begin
            dest = int'(iv_command[63:56]);
            if (iv_command[65:64] == 2'b01 && dest <= N) begin
                if (dest == 0) begin
                    m_hcp = iv_command[63:0];
                    m_hwr = 1'b1;
                end else begin
                    m_ts[64*(dest-1) +: 64] = iv_command[63:0];
                    m_twr[dest-1] = 1'b1;
                end
            end else begin
                m_pd = (m_pd + 1 > 65535) ? 65535 : m_pd + 1;
            end
        end
        if (!m_ov || i_command_rdy) begin
            g = -1;
            for (int i = 0; i < NS; i++) begin
                if (g < 0 && mq[(m_next + i) % NS].size() > 0) g = (m_next + i) % NS;
            end
            if (g >= 0) begin
                w = mq[g].pop_front();
                m_oc = {(g == 0) ? 2'b01 : 2'b10, 8'(g), w[55:0]};
                m_ov = 1;
                m_next = (g + 1) % NS;
            end else begin
                m_ov = 0;
            end
        end
        drops = 0;
        if (i_command_wr_from_interior) begin
            if (mq[0].size() < D) mq[0].push_back(iv_command_from_interior);
            else drops++;
        end
        for (int k = 0; k < N; k++) begin
            if (i_command_wr_from_external[k]) begin
                if (mq[k+1].size() < D) mq[k+1].push_back(iv_command_from_external[64*k +: 64]);
                else drops++;
            end
        end
        m_fd = (m_fd + drops > 65535) ? 65535 : m_fd + drops;
    endtask

    task automatic compare_all();
        chk("ov_command",   256'(ov_command),          256'(m_oc));
        chk("o_command_wr", 256'(o_command_wr),        256'(m_ov));
        chk("hcp_cmd",      256'(ov_hcp_command),      256'(m_hcp));
        chk("hcp_wr",       256'(o_hcp_command_wr),    256'(m_hwr));
        chk("ts_cmd",       256'(ov_tsstse_command),   256'(m_ts));
        chk("ts_wr",        256'(o_tsstse_command_wr), 256'(m_twr));
        chk("parse_drop",   256'(ov_parse_drop_cnt),   256'(m_pd));
        chk("fifo_drop",    256'(ov_fifo_drop_cnt),    256'(m_fd));
    endtask

    task automatic cyc();
        @(posedge i_clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        i_rst = 1'b1;
        iv_command = '0;
        i_command_wr = 1'b0;
        iv_command_from_interior = '0;
        i_command_wr_from_interior = 1'b0;
        iv_command_from_external = '0;
        i_command_wr_from_external = '0;
        i_command_rdy = 1'b1;
        cyc();
        cyc();
        i_rst = 1'b0;
        chk("rst_owr",   256'(o_command_wr),      256'(0));
        chk("rst_ocmd",  256'(ov_command),        256'(0));
        chk("rst_pdrop", 256'(ov_parse_drop_cnt), 256'(0));
        chk("rst_fdrop", 256'(ov_fifo_drop_cnt),  256'(0));

        // HCP dispatch
        iv_command = {2'b01, 8'h00, 56'h1234};
        i_command_wr = 1'b1;
        cyc();
        i_command_wr = 1'b0;
        chk("hcp_wr_dir",  256'(o_hcp_command_wr),    256'(1));
        chk("hcp_dat_dir", 256'(ov_hcp_command),      256'(64'h1234));
        chk("hcp_ts0_dir", 256'(o_tsstse_command_wr), 256'(0));

        // TSSTSE dispatch, then out-of-range destination
        iv_command = {2'b01, 8'h02, 56'hABCD};
        i_command_wr = 1'b1;
        cyc();
        chk("ts_wr_dir",  256'(o_tsstse_command_wr),      256'(3'b010));
        chk("ts_dat_dir", 256'(ov_tsstse_command[127:64]), 256'({8'h02, 56'hABCD}));
        iv_command = {2'b01, 8'h04, 56'h5555};
        cyc();
        i_command_wr = 1'b0;
        chk("bad_dest_wr",  256'({o_hcp_command_wr, o_tsstse_command_wr}), 256'(0));
        chk("bad_dest_cnt", 256'(ov_parse_drop_cnt), 256'(1));

        // one word per source in the same cycle
        iv_command_from_interior = 64'hFF00_0000_0000_0A00;
        for (int k = 0; k < N; k++)
            iv_command_from_external[64*k +: 64] = 64'hEE00_0000_0000_0B00 + 64'(k);
        i_command_wr_from_interior = 1'b1;
        i_command_wr_from_external = '1;
        cyc();
        i_command_wr_from_interior = 1'b0;
        i_command_wr_from_external = '0;
        chk("lat_not_yet", 256'(o_command_wr), 256'(0));
        cyc();
        chk("rr0", 256'({o_command_wr, ov_command}), 256'({1'b1, 2'b01, 8'd0, 56'h0A00}));
        for (int k = 0; k < N; k++) begin
            cyc();
            chk("rr_ext", 256'({o_command_wr, ov_command}),
                256'({1'b1, 2'b10, 8'(k + 1), 56'h0B00 + 56'(k)}));
        end
        cyc();
        chk("rr_idle", 256'(o_command_wr), 256'(0));

        // fill external 0 with downstream stalled
        i_command_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            iv_command_from_external[63:0] = 64'h100 + 64'(i);
            i_command_wr_from_external = 3'b001;
            cyc();
        end
        i_command_wr_from_external = '0;
        cyc();
        chk("stall_frozen", 256'({o_command_wr, ov_command}), 256'({1'b1, 2'b10, 8'd1, 56'h100}));
        chk("stall_drop",   256'(ov_fifo_drop_cnt), 256'(1));

        // push into the full FIFO on the cycle it pops
        i_command_rdy = 1'b1;
        iv_command_from_external[63:0] = 64'h200;
        i_command_wr_from_external = 3'b001;
        cyc();
        i_command_wr_from_external = '0;
        chk("full_pop_push_drop", 256'(ov_fifo_drop_cnt), 256'(1));
        chk("drain1", 256'(ov_command[55:0]), 256'(56'h101));
        for (int i = 2; i <= 8; i++) begin
            cyc();
            chk("drain", 256'(ov_command[55:0]), 256'(56'h100 + 56'(i)));
        end
        cyc();
        chk("drain_last", 256'(ov_command[55:0]), 256'(56'h200));
        cyc();

        // reset while output valid and FIFOs non-empty
        i_command_rdy = 1'b0;
        iv_command_from_interior = 64'h77;
        i_command_wr_from_interior = 1'b1;
        i_command_wr_from_external = 3'b010;
        repeat (3) cyc();
        i_command_wr_from_interior = 1'b0;
        i_command_wr_from_external = '0;
        chk("pre_rst_owr", 256'(o_command_wr), 256'(1));
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        i_command_rdy = 1'b1;
        chk("mid_rst_out", 256'({o_command_wr, ov_command, ov_fifo_drop_cnt, ov_parse_drop_cnt}), 256'(0));
        repeat (3) begin
            cyc();
            chk("post_rst_idle", 256'(o_command_wr), 256'(0));
        end

        // random traffic
        for (int c = 0; c < 600; c++) begin
            i_rst = ($urandom_range(0, 249) == 0);
            i_command_wr = ($urandom_range(0, 1) == 1);
            iv_command = {($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01,
                          8'($urandom_range(0, 5)), 56'({$urandom(), $urandom()})};
            iv_command_from_interior = {$urandom(), $urandom()};
            i_command_wr_from_interior = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < N; k++) begin
                iv_command_from_external[64*k +: 64] = {$urandom(), $urandom()};
                i_command_wr_from_external[k] = ($urandom_range(0, 2) == 0);
            end
            if (c % 80 < 25) i_command_rdy = ($urandom_range(0, 7) == 0);
            else i_command_rdy = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
